r_cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the R-type CPU. Drives the program counter increment, instruction register load, register-file read/write strobes and ALU operation select, stepping each instruction through FETCH, DECODE, EXECUTE and WRITEBACK. Sits between the program counter, instruction memory, register file and ALU, and owns the only state machine in the core.

---
 rtl/r_cpu_pkg.sv | 41 ++++
 rtl/r_cpu_funct_decode.sv | 30 +++
 rtl/r_cpu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_r_cpu_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r_cpu_pkg.sv
// r_cpu_pkg: shared definitions for the R-type CPU core.
// Holds the sequencer state encoding, the opcode and funct constants and
// the alu_op encodings that both the sequencer and the ALU import.
package r_cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } seq_state_t;

    // Opcode field ir[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // Funct field ir[5:0] for the supported R-type operations
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;

    // ALU operation select encodings
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;

endpackage

// File: rtl/r_cpu_funct_decode.sv
// r_cpu_funct_decode: combinational funct -> alu_op mapping.
// legal is low for any funct outside the supported set; alu_op is then
// a don't-care and is driven to ALU_ADD.
module r_cpu_funct_decode
    import r_cpu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       legal
);

    // Table lookup of the supported funct codes
    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_XOR:  alu_op = ALU_XOR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SLL:  alu_op = ALU_SLL;
            FN_SRL:  alu_op = ALU_SRL;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/r_cpu_sequencer.sv
// r_cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control FSM.
// Strobes pc_inc, alu_en and rf_we are registered: each is high in the
// cycle after the state that decides it (pc_inc during DECODE, alu_en
// during WRITEBACK, rf_we in the cycle following WRITEBACK).
// Optional build macro R_CPU_SEQ_PERF_EN adds the retired and
// stall_cycles performance counters as extra output ports.
module r_cpu_sequencer
    import r_cpu_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 15
) (
    input  logic        clka,
    input  logic        rsta_n,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        pc_inc,
    output logic [31:0] ir,
    output logic [4:0]  rf_raddr_a,
    output logic [4:0]  rf_raddr_b,
    output logic [4:0]  rf_waddr,
    output logic        rf_we,
    output logic        alu_en,
    output logic [3:0]  alu_op,
    output logic [4:0]  shamt,
    output logic        halted,
    output logic        fault
`ifdef R_CPU_SEQ_PERF_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] stall_cycles
`endif
);

    localparam int              WAIT_W    = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMEM_TIMEOUT - 1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_clr;
    logic              wait_inc;
    logic              ir_load;
    logic              alu_op_load;
    logic              fault_set;
    logic              pc_inc_nxt;
    logic              alu_en_nxt;
    logic              rf_we_nxt;
    logic [3:0]        dec_alu_op;
    logic              dec_legal;
    logic [5:0]        opcode;

    assign opcode     = ir[31:26];
    assign rf_raddr_a = ir[25:21];
    assign rf_raddr_b = ir[20:16];
    assign rf_waddr   = ir[15:11];
    assign shamt      = ir[10:6];

    r_cpu_funct_decode u_funct_decode (
        .funct  (ir[5:0]),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    // Next-state and per-state control decisions
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        wait_clr    = 1'b1;
        wait_inc    = 1'b0;
        ir_load     = 1'b0;
        alu_op_load = 1'b0;
        fault_set   = 1'b0;
        pc_inc_nxt  = 1'b0;
        alu_en_nxt  = 1'b0;
        rf_we_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                wait_clr = 1'b0;
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    pc_inc_nxt = 1'b1;
                    wait_clr   = 1'b1;
                    state_nxt  = ST_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Last permitted wait cycle passed with no data
                    fault_set = 1'b1;
                    state_nxt = ST_HALT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_nxt = ST_HALT;
                end else if (opcode != OP_RTYPE || !dec_legal) begin
                    fault_set = 1'b1;
                    state_nxt = ST_HALT;
                end else begin
                    alu_op_load = 1'b1;
                    state_nxt   = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                alu_en_nxt = 1'b1;
                state_nxt  = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                // r0 is hardwired, so writes to it are dropped here
                rf_we_nxt = (rf_waddr != 5'd0);
                state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and FETCH wait counter
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (wait_clr)      wait_cnt <= '0;
            else if (wait_inc) wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Registered strobes, instruction/op latches and sticky status
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            pc_inc <= 1'b0;
            alu_en <= 1'b0;
            rf_we  <= 1'b0;
            ir     <= '0;
            alu_op <= '0;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            pc_inc <= pc_inc_nxt;
            alu_en <= alu_en_nxt;
            rf_we  <= rf_we_nxt;
            if (ir_load)     ir     <= imem_rdata;
            if (alu_op_load) alu_op <= dec_alu_op;
            halted <= (state_nxt == ST_HALT);
            fault  <= fault | fault_set;
        end
    end

`ifdef R_CPU_SEQ_PERF_EN
    // Retired-instruction and fetch-stall counters, free-running wrap
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            retired      <= '0;
            stall_cycles <= '0;
        end else begin
            if (state == ST_WRITEBACK)          retired      <= retired + 32'd1;
            if (state == ST_FETCH && !imem_ack) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_r_cpu_sequencer.sv
// tb_r_cpu_sequencer: directed bench for r_cpu_sequencer.
// Each scenario is planned as an expected per-cycle timeline built from
// instruction-level rules (FETCH wait count, strobe offsets, halt rules),
// then replayed against the DUT with one compare per cycle.
// Honours R_CPU_SEQ_PERF_EN for the optional counter ports.
module tb_r_cpu_sequencer;

    logic        clka = 1'b0;
    logic        rsta_n;
    logic        run;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_inc;
    logic [31:0] ir;
    logic [4:0]  rf_raddr_a;
    logic [4:0]  rf_raddr_b;
    logic [4:0]  rf_waddr;
    logic        rf_we;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic [4:0]  shamt;
    logic        halted;
    logic        fault;
`ifdef R_CPU_SEQ_PERF_EN
    logic [31:0] retired;
    logic [31:0] stall_cycles;
`endif

    r_cpu_sequencer #(.IMEM_TIMEOUT(15)) dut (
        .clka       (clka),
        .rsta_n     (rsta_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_inc     (pc_inc),
        .ir         (ir),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .shamt      (shamt),
        .halted     (halted),
        .fault      (fault)
`ifdef R_CPU_SEQ_PERF_EN
        ,
        .retired      (retired),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clka = ~clka;

    typedef struct packed {
        logic        run;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic        pc_inc;
        logic        alu_en;
        logic        rf_we;
        logic        halted;
        logic        fault;
        logic        chk_op;
        logic [3:0]  op;
        logic        chk_ir;
        logic [31:0] irv;
    } cyc_t;

    cyc_t        tl [0:255];
    int          tl_len;
    logic        m_halted, m_fault;
    logic        pend, pend_we;
    logic [31:0] pend_ir;
    logic [31:0] exp_stall, exp_ret;

    int n_checks = 0;
    int n_pass   = 0;

    int first_pc, first_alu, first_we, first_halt;
    int cnt_pc, cnt_alu, cnt_we;
    logic [31:0] we_addr_seen, alu_op_seen;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    endtask

    // Spec table: funct -> alu_op, -1 when unsupported
    function automatic int model_op(input logic [5:0] fn);
        case (fn)
            6'h20: return 0;
            6'h22: return 1;
            6'h24: return 2;
            6'h25: return 3;
            6'h26: return 4;
            6'h27: return 5;
            6'h2A: return 6;
            6'h00: return 7;
            6'h02: return 8;
            default: return -1;
        endcase
    endfunction

    task automatic start_scenario();
        tl_len = 0; m_halted = 0; m_fault = 0; pend = 0; pend_we = 0; pend_ir = '0;
        exp_stall = '0; exp_ret = '0;
        first_pc = -1; first_alu = -1; first_we = -1; first_halt = -1;
        cnt_pc = 0; cnt_alu = 0; cnt_we = 0; we_addr_seen = '1; alu_op_seen = '1;
    endtask

    task automatic push(input logic run_v);
        cyc_t e;
        e = '0;
        e.run = run_v;
        e.halted = m_halted;
        e.fault = m_fault;
        if (pend) begin
            e.rf_we = pend_we;
            e.chk_ir = 1'b1;
            e.irv = pend_ir;
            pend = 1'b0;
        end
        tl[tl_len] = e;
        tl_len++;
    endtask

    task automatic plan_instr(input logic [31:0] instr, input int w, input logic run_wb);
        int op;
        for (int k = 0; k <= w; k++) begin
            push(1'b1);
            tl[tl_len-1].req   = 1'b1;
            tl[tl_len-1].ack   = (k == w);
            tl[tl_len-1].rdata = (k == w) ? instr : ~instr;
        end
        push(1'b1);
        tl[tl_len-1].pc_inc = 1'b1;
        tl[tl_len-1].chk_ir = 1'b1;
        tl[tl_len-1].irv    = instr;
        op = model_op(instr[5:0]);
        if (instr[31:26] == 6'h3F) begin
            m_halted = 1'b1;
            return;
        end
        if (instr[31:26] != 6'h00 || op < 0) begin
            m_halted = 1'b1;
            m_fault  = 1'b1;
            return;
        end
        push(1'b1);
        tl[tl_len-1].chk_ir = 1'b1; tl[tl_len-1].irv = instr;
        tl[tl_len-1].chk_op = 1'b1; tl[tl_len-1].op  = 4'(op);
        push(run_wb);
        tl[tl_len-1].alu_en = 1'b1;
        tl[tl_len-1].chk_ir = 1'b1; tl[tl_len-1].irv = instr;
        tl[tl_len-1].chk_op = 1'b1; tl[tl_len-1].op  = 4'(op);
        pend = 1'b1; pend_we = (instr[15:11] != 5'd0); pend_ir = instr;
    endtask

    task automatic plan_timeout();
        for (int k = 0; k < 15; k++) begin
            push(1'b1);
            tl[tl_len-1].req = 1'b1;
            tl[tl_len-1].rdata = 32'h0000_1820;
        end
        m_halted = 1'b1;
        m_fault  = 1'b1;
    endtask

    task automatic plan_halt_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            push(1'b1);
            tl[tl_len-1].ack   = 1'b1;
            tl[tl_len-1].rdata = $urandom;
        end
    endtask

    task automatic compare(input int i);
        cyc_t e;
        int rel;
        e = tl[i];
        rel = i - 1;
        chk("imem_req", i, 32'(imem_req), 32'(e.req));
        chk("pc_inc",   i, 32'(pc_inc),   32'(e.pc_inc));
        chk("alu_en",   i, 32'(alu_en),   32'(e.alu_en));
        chk("rf_we",    i, 32'(rf_we),    32'(e.rf_we));
        chk("halted",   i, 32'(halted),   32'(e.halted));
        chk("fault",    i, 32'(fault),    32'(e.fault));
        if (e.chk_op) chk("alu_op", i, 32'(alu_op), 32'(e.op));
        if (e.chk_ir) begin
            chk("ir",         i, ir,                e.irv);
            chk("rf_raddr_a", i, 32'(rf_raddr_a),   32'(e.irv[25:21]));
            chk("rf_raddr_b", i, 32'(rf_raddr_b),   32'(e.irv[20:16]));
            chk("rf_waddr",   i, 32'(rf_waddr),     32'(e.irv[15:11]));
            chk("shamt",      i, 32'(shamt),        32'(e.irv[10:6]));
        end
`ifdef R_CPU_SEQ_PERF_EN
        chk("stall_cycles", i, stall_cycles, exp_stall);
        chk("retired",      i, retired,      exp_ret);
        if (e.req && !e.ack) exp_stall++;
        if (e.alu_en) exp_ret++;
`endif
        if (pc_inc) begin cnt_pc++; if (first_pc < 0) first_pc = rel; end
        if (alu_en) begin
            cnt_alu++;
            if (first_alu < 0) begin first_alu = rel; alu_op_seen = 32'(alu_op); end
        end
        if (rf_we) begin
            cnt_we++;
            if (first_we < 0) begin first_we = rel; we_addr_seen = 32'(rf_waddr); end
        end
        if (halted && first_halt < 0) first_halt = rel;
    endtask

    task automatic run_tl(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clka);
            #1;
            run        = tl[i].run;
            imem_ack   = tl[i].ack;
            imem_rdata = tl[i].rdata;
            @(negedge clka);
            compare(i);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"},    0, 32'(imem_req), 32'd0);
        chk({tag, "_pc_inc"}, 0, 32'(pc_inc),   32'd0);
        chk({tag, "_alu_en"}, 0, 32'(alu_en),   32'd0);
        chk({tag, "_rf_we"},  0, 32'(rf_we),    32'd0);
        chk({tag, "_ir"},     0, ir,            32'd0);
        chk({tag, "_alu_op"}, 0, 32'(alu_op),   32'd0);
        chk({tag, "_waddr"},  0, 32'(rf_waddr), 32'd0);
        chk({tag, "_halted"}, 0, 32'(halted),   32'd0);
        chk({tag, "_fault"},  0, 32'(fault),    32'd0);
`ifdef R_CPU_SEQ_PERF_EN
        chk({tag, "_retired"}, 0, retired,      32'd0);
        chk({tag, "_stall"},   0, stall_cycles, 32'd0);
`endif
    endtask

    task automatic do_reset();
        run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        rsta_n = 1'b0;
        repeat (2) @(posedge clka);
        @(negedge clka);
        check_zero("reset");
        rsta_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    typedef struct packed { logic [31:0] instr; logic exp_fault; } halt_case_t;
    halt_case_t halt_cases [3];

    initial begin
        rsta_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

        // Mixed legal instructions back to back, with waits and a run drop
        do_reset();
        start_scenario();
        push(1'b1);
        plan_instr(32'h0022_1820, 0, 1'b1);  // add r3,r1,r2
        plan_instr(32'h0085_3025, 0, 1'b1);  // or
        plan_instr(32'h000A_4880, 1, 1'b1);  // sll
        plan_instr(32'h000B_50C2, 0, 1'b1);  // srl
        plan_instr(32'h0109_5826, 2, 1'b1);  // xor
        plan_instr(32'h00A6_3024, 0, 1'b1);  // and
        plan_instr(32'h014B_6027, 0, 1'b0);  // nor, then idle
        push(1'b0); push(1'b0);
        run_tl(tl_len);
        chk("add_pc_cycle",  0, 32'(first_pc),  32'd1);
        chk("add_alu_cycle", 0, 32'(first_alu), 32'd3);
        chk("add_alu_op",    0, alu_op_seen,    32'd0);
        chk("add_we_cycle",  0, 32'(first_we),  32'd4);
        chk("add_we_addr",   0, we_addr_seen,   32'd3);

        // rd=0 suppresses the write; then restart from IDLE
        do_reset();
        start_scenario();
        push(1'b1);
        plan_instr(32'h0022_0022, 0, 1'b0);  // sub r0,r1,r2
        push(1'b0); push(1'b0); push(1'b1);
        plan_instr(32'h0022_1820, 0, 1'b0);
        push(1'b0); push(1'b0);
        run_tl(tl_len);
        chk("rd0_alu_cnt", 0, 32'(cnt_alu), 32'd2);
        chk("rd0_we_cnt",  0, 32'(cnt_we),  32'd1);

        // imem_ack delayed by 3 cycles
        do_reset();
        start_scenario();
        push(1'b1);
        plan_instr(32'h00A6_382A, 3, 1'b0);  // slt r7,r5,r6
        push(1'b0); push(1'b0);
        run_tl(tl_len);
        chk("delay_pc_cnt",   0, 32'(cnt_pc),   32'd1);
        chk("delay_pc_cycle", 0, 32'(first_pc), 32'd4);
`ifdef R_CPU_SEQ_PERF_EN
        chk("delay_stall", 0, stall_cycles, 32'd3);
        chk("delay_ret",   0, retired,      32'd1);
`endif

        // imem_ack never arrives
        do_reset();
        start_scenario();
        push(1'b1);
        plan_timeout();
        plan_halt_cycles(4);
        run_tl(tl_len);
        chk("tmo_pc_cnt",     0, 32'(cnt_pc),     32'd0);
        chk("tmo_halt_cycle", 0, 32'(first_halt), 32'd15);
        chk("tmo_fault",      0, 32'(fault),      32'd1);

        // Halt opcode, non-R opcode, unsupported funct
        halt_cases[0] = '{32'h8C00_0000, 1'b1};
        halt_cases[1] = '{32'hFC00_0000, 1'b0};
        halt_cases[2] = '{32'h0022_1821, 1'b1};
        for (int c = 0; c < 3; c++) begin
            do_reset();
            start_scenario();
            push(1'b1);
            plan_instr(halt_cases[c].instr, 0, 1'b1);
            plan_halt_cycles(3);
            run_tl(tl_len);
            chk("stop_halted", c, 32'(halted),  32'd1);
            chk("stop_fault",  c, 32'(fault),   32'(halt_cases[c].exp_fault));
            chk("stop_alu",    c, 32'(cnt_alu), 32'd0);
        end

        // Reset asserted during EXECUTE, then a clean instruction
        do_reset();
        start_scenario();
        push(1'b1);
        plan_instr(32'h0022_2022, 0, 1'b1);  // sub r4,r1,r2
        run_tl(4);                           // IDLE, FETCH, DECODE, EXECUTE
        #1;
        rsta_n = 1'b0;
        #1;
        check_zero("midreset");
        do_reset();
        start_scenario();
        push(1'b1);
        plan_instr(32'h0022_1820, 0, 1'b0);
        push(1'b0); push(1'b0);
        run_tl(tl_len);
        chk("after_rst_we_cnt",   0, 32'(cnt_we),   32'd1);
        chk("after_rst_we_cycle", 0, 32'(first_we), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
